// File: rtl/mastermind_game_if.sv
// Guess/score handshake and game-control bundle between the pin decoder,
// the game controller and the display mux.
interface mastermind_game_if;
  logic        start;
  logic        secret_load;
  logic [11:0] secret_in;
  logic        guess_valid;
  logic [11:0] guess;
  logic        guess_ready;
  logic        guess_err;
  logic        score_valid;
  logic [2:0]  black;
  logic [2:0]  white;
  logic [3:0]  turn;
  logic        won;
  logic        lost;
  logic        busy;

  modport master (
    output start, secret_load, secret_in, guess_valid, guess,
    input  guess_ready, guess_err, score_valid, black, white, turn, won, lost, busy
  );

  modport slave (
    input  start, secret_load, secret_in, guess_valid, guess,
    output guess_ready, guess_err, score_valid, black, white, turn, won, lost, busy
  );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: latches the secret, accepts guesses, scores
// them over NUM_COLOURS+2 cycles and tracks turns, win and loss.
module mastermind_game_ctrl #(
  parameter int          MAX_TURNS   = 10,
  parameter int          NUM_COLOURS = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  mastermind_game_if.slave gi
);
  localparam logic [3:0] NC = 4'(NUM_COLOURS);
  localparam logic [3:0] MT = 4'(MAX_TURNS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_SCORE_B = 3'd2;
  localparam logic [2:0] S_SCORE_W = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_WON     = 3'd5;
  localparam logic [2:0] S_LOST    = 3'd6;

  // Out-of-range colour codes fold back into range by one subtraction.
  function automatic logic [2:0] fold(input logic [2:0] v);
    return ({1'b0, v} >= NC) ? v - NC[2:0] : v;
  endfunction

  function automatic logic legal(input logic [11:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if ({1'b0, p[3*i +: 3]} >= NC) ok = 1'b0;
    return ok;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] secret_q, guess_q, secret_new;
  logic [2:0]  black_acc_q, match_acc_q, col_q;
  logic [2:0]  black_q, white_q;
  logic [3:0]  turn_q;
  logic        sv_q, err_q, won_q, lost_q;
  logic        ready_int;
  logic [2:0]  bsum, cnt_s, cnt_g, cmin;

  // Ready is held off for the score_valid cycle so the next guess follows
  // the result by one edge.
  assign ready_int = (state_q == S_WAIT) && !gi.start && !sv_q;

  // Galois step (taps 16,14,13,11) and the folded secret offered at start.
  always_comb begin
    logic [11:0] src;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    src    = gi.secret_load ? gi.secret_in : lfsr_q[11:0];
    secret_new = '0;
    for (int i = 0; i < 4; i++) secret_new[3*i +: 3] = fold(src[3*i +: 3]);
  end

  // Exact-match count and per-colour min(secret, guess) for colour col_q.
  always_comb begin
    bsum  = '0;
    cnt_s = '0;
    cnt_g = '0;
    for (int i = 0; i < 4; i++) begin
      bsum  = bsum  + {2'b00, guess_q[3*i +: 3] == secret_q[3*i +: 3]};
      cnt_s = cnt_s + {2'b00, secret_q[3*i +: 3] == col_q};
      cnt_g = cnt_g + {2'b00, guess_q[3*i +: 3] == col_q};
    end
    cmin = (cnt_s < cnt_g) ? cnt_s : cnt_g;
  end

  // Next-state logic; start overrides everything, including a score in flight.
  always_comb begin
    state_d = state_q;
    if (gi.start) state_d = S_WAIT;
    else begin
      case (state_q)
        S_WAIT:    if (ready_int && gi.guess_valid && legal(gi.guess)) state_d = S_SCORE_B;
        S_SCORE_B: state_d = S_SCORE_W;
        S_SCORE_W: if (col_q == 3'(NC - 4'd1)) state_d = S_REPORT;
        S_REPORT: begin
          if (black_acc_q == 3'd4)        state_d = S_WON;
          else if (turn_q + 4'd1 == MT)   state_d = S_LOST;
          else                            state_d = S_WAIT;
        end
        default:   state_d = state_q;
      endcase
    end
  end

  // Game registers; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      secret_q    <= '0;
      guess_q     <= '0;
      black_acc_q <= '0;
      match_acc_q <= '0;
      col_q       <= '0;
      black_q     <= '0;
      white_q     <= '0;
      turn_q      <= '0;
      sv_q        <= 1'b0;
      err_q       <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
      if (gi.start) begin
        secret_q <= secret_new;
        turn_q   <= '0;
        black_q  <= '0;
        white_q  <= '0;
        won_q    <= 1'b0;
        lost_q   <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT: if (ready_int && gi.guess_valid) begin
            if (legal(gi.guess)) guess_q <= gi.guess;
            else                 err_q   <= 1'b1;
          end
          S_SCORE_B: begin
            black_acc_q <= bsum;
            match_acc_q <= '0;
            col_q       <= '0;
          end
          S_SCORE_W: begin
            match_acc_q <= match_acc_q + cmin;
            col_q       <= col_q + 3'd1;
          end
          S_REPORT: begin
            black_q <= black_acc_q;
            white_q <= match_acc_q - black_acc_q;
            turn_q  <= turn_q + 4'd1;
            sv_q    <= 1'b1;
          end
          S_WON:   won_q  <= 1'b1;
          S_LOST:  lost_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign gi.guess_ready = ena && ready_int;
  assign gi.guess_err   = ena && err_q;
  assign gi.score_valid = ena && sv_q;
  assign gi.black       = black_q;
  assign gi.white       = white_q;
  assign gi.turn        = turn_q;
  assign gi.won         = won_q;
  assign gi.lost        = lost_q;
  assign gi.busy        = (state_q == S_SCORE_B) || (state_q == S_SCORE_W) || (state_q == S_REPORT);
endmodule
